dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_responder.sv | 199 +++++++++++++++++++
 tb/tb_dbus_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - Fixed-latency data-bus responder backed by a 64-bit word store
//
// Purpose:
//   Serves one data-bus request at a time. A request presented in IDLE is
//   accepted combinationally and latched. The responder then waits LATENCY
//   cycles and answers with a single-cycle response.
//   - Reads return the whole aligned 64-bit word.
//   - Writes update only the strobed byte lanes and answer with zero data.
//   - Misaligned, illegal-size and out-of-range requests complete normally,
//     with dresp_err set, and never touch the store.
//
// Parameters:
//   DEPTH_WORDS  number of 64-bit words in the backing store
//   LATENCY      wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous active-low reset
//   dreq_valid     in   1   request present; held stable until dresp_data_ok
//   dreq_addr      in   64  byte address
//   dreq_size      in   3   0=1B 1=2B 2=4B 3=8B, 4..7 illegal
//   dreq_strobe    in   8   byte-lane write enables, all-zero = read
//   dreq_data      in   64  lane-aligned write data
//   dresp_addr_ok  out  1   request accepted this cycle
//   dresp_data_ok  out  1   response valid this cycle
//   dresp_data     out  64  aligned read word, zero on error or write
//   dresp_err      out  1   misaligned / illegal / out-of-range access
module dbus_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        dresp_err
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // The wait counter counts down to zero, so it starts one below LATENCY.
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;

  // Latched request
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;

  // Backing store. It has no reset, so its contents survive reset.
  logic [63:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_in_resp;
  logic             w_misalign;
  logic             w_illegal;
  logic             w_oob;
  logic             w_err;
  logic             w_is_write;
  logic             w_commit;
  logic [60:0]      w_word_idx;
  logic [IDX_W-1:0] w_mem_idx;
  logic [63:0]      w_rd_word;

  // ---------------------------------------------------------------------
  // Request decode (always on the latched copy)
  // ---------------------------------------------------------------------
  // While reset is low, nothing may be accepted, even in IDLE.
  assign w_accept   = reset && (r_state == S_IDLE) && dreq_valid;
  assign w_in_resp  = reset && (r_state == S_RESP);

  assign w_word_idx = r_addr[63:3];
  assign w_mem_idx  = w_word_idx[IDX_W-1:0];
  assign w_oob      = ({3'b000, w_word_idx} >= 64'(DEPTH_WORDS));
  assign w_illegal  = r_size[2];
  assign w_is_write = (r_strobe != 8'h00);
  assign w_err      = w_misalign || w_illegal || w_oob;

  always_comb begin
    w_misalign = 1'b0;
    case (r_size[1:0])
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = r_addr[0];
      2'd2:    w_misalign = |r_addr[1:0];
      default: w_misalign = |r_addr[2:0];
    endcase
  end

  // A write commits at the RESP edge, and only if reset is still high there.
  assign w_commit  = w_in_resp && w_is_write && !w_err;

  // The index may point past a non-power-of-two store when w_oob is set.
  // That read value is discarded by the error mux on the output.
  assign w_rd_word = r_mem[w_mem_idx];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (dreq_valid) begin
          w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end
      end
      // RESP always lasts one cycle. The following IDLE cycle is the
      // mandatory gap between transactions.
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    dresp_addr_ok = w_accept;
    dresp_data_ok = w_in_resp;
    dresp_err     = w_in_resp && w_err;
    dresp_data    = 64'd0;
    if (w_in_resp && !w_err && !w_is_write) begin
      dresp_data = w_rd_word;
    end
  end

  // ---------------------------------------------------------------------
  // Wait counter and request latch
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= LAT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr   <= 64'd0;
      r_size   <= 3'd0;
      r_strobe <= 8'd0;
      r_data   <= 64'd0;
    end else if (w_accept) begin
      r_addr   <= dreq_addr;
      r_size   <= dreq_size;
      r_strobe <= dreq_strobe;
      r_data   <= dreq_data;
    end
  end

  // ---------------------------------------------------------------------
  // Store write port. Strobes are used exactly as given, including lanes
  // outside the window selected by the access size.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) begin
          r_mem[w_mem_idx][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - Directed self-checking bench for dbus_responder
module tb_dbus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // LATENCY=2 instance (sel=0)
  logic        v2;
  logic [63:0] a2;
  logic [2:0]  s2;
  logic [7:0]  st2;
  logic [63:0] d2;
  logic        aok2, dok2, err2;
  logic [63:0] rd2;

  // LATENCY=0 instance (sel=1)
  logic        v0;
  logic [63:0] a0;
  logic [2:0]  s0;
  logic [7:0]  st0;
  logic [63:0] d0;
  logic        aok0, dok0, err0;
  logic [63:0] rd0;

  int n_cmp = 0;
  int n_bad = 0;

  dbus_responder #(.DEPTH_WORDS(16), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .dreq_valid(v2), .dreq_addr(a2), .dreq_size(s2), .dreq_strobe(st2), .dreq_data(d2),
    .dresp_addr_ok(aok2), .dresp_data_ok(dok2), .dresp_data(rd2), .dresp_err(err2)
  );

  dbus_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .dreq_valid(v0), .dreq_addr(a0), .dreq_size(s0), .dreq_strobe(st0), .dreq_data(d0),
    .dresp_addr_ok(aok0), .dresp_data_ok(dok0), .dresp_data(rd0), .dresp_err(err0)
  );

  task automatic drive(input bit sel, input logic v, input logic [63:0] a, input logic [2:0] s,
                       input logic [7:0] st, input logic [63:0] d);
    if (sel) begin
      v0 = v; a0 = a; s0 = s; st0 = st; d0 = d;
    end else begin
      v2 = v; a2 = a; s2 = s; st2 = st; d2 = d;
    end
  endtask

  function automatic logic get_aok(input bit sel);
    return sel ? aok0 : aok2;
  endfunction

  function automatic logic get_dok(input bit sel);
    return sel ? dok0 : dok2;
  endfunction

  // Runs one request with valid held until data_ok. lat is the number of
  // cycles from addr_ok to data_ok; 100 is added if a second addr_ok shows
  // up while waiting. If addr_ok never arrives, lat is -1.
  task automatic xact(input bit sel, input logic [63:0] a, input logic [2:0] s,
                      input logic [7:0] st, input logic [63:0] d,
                      output int lat, output logic [63:0] rd, output logic re);
    int n;
    int extra;
    @(posedge clk); #1;
    drive(sel, 1'b1, a, s, st, d);
    @(negedge clk);
    n   = 0;
    lat = -1;
    rd  = 64'hX;
    re  = 1'bx;
    while (!get_aok(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (get_aok(sel)) begin
      lat   = 0;
      extra = 0;
      do begin
        @(negedge clk);
        lat++;
        if (get_aok(sel)) extra++;
      end while (!get_dok(sel) && lat < 20);
      rd = sel ? rd0 : rd2;
      re = sel ? err0 : err2;
      if (extra != 0) lat += 100;
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(0, 1'b1, 64'h80, 3'd3, 8'h00, 64'd0);
    drive(1, 1'b1, 64'h80, 3'd3, 8'h00, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (aok2 !== 1'b0) begin n_bad++; $display("FAIL rst_aok2: got %b want 0", aok2); end
    n_cmp++; if (dok2 !== 1'b0) begin n_bad++; $display("FAIL rst_dok2: got %b want 0", dok2); end
    n_cmp++; if (rd2 !== 64'd0) begin n_bad++; $display("FAIL rst_data2: got %h want 0", rd2); end
    n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL rst_err2: got %b want 0", err2); end
    n_cmp++; if (aok0 !== 1'b0) begin n_bad++; $display("FAIL rst_aok0: got %b want 0", aok0); end
    // Release reset with a request already present: it must be accepted at once.
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (aok2 !== 1'b1) begin n_bad++; $display("FAIL first_aok2: got %b want 1", aok2); end
    n_cmp++; if (aok0 !== 1'b1) begin n_bad++; $display("FAIL first_aok0: got %b want 1", aok0); end
    @(posedge clk); #1;
    drive(1, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
    @(negedge clk);
    n_cmp++; if (dok0 !== 1'b1 || err0 !== 1'b1) begin n_bad++; $display("FAIL first_resp0: got dok=%b err=%b want 1 1", dok0, err0); end
    n_cmp++; if (dok2 !== 1'b0) begin n_bad++; $display("FAIL first_early2: got dok=%b want 0", dok2); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (dok2 !== 1'b1 || err2 !== 1'b1 || rd2 !== 64'd0) begin
      n_bad++; $display("FAIL first_resp2: got dok=%b err=%b data=%h want 1 1 0", dok2, err2, rd2);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
  endtask

  task automatic test_write_full;
    int lat;
    logic [63:0] rd;
    logic re;
    xact(0, 64'h10, 3'd3, 8'hFF, 64'h1122334455667788, lat, rd, re);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr10_lat: got %0d want 3", lat); end
    n_cmp++; if (re !== 1'b0 || rd !== 64'd0) begin n_bad++; $display("FAIL wr10_resp: got err=%b data=%h want 0 0", re, rd); end
    xact(0, 64'h10, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd10_lat: got %0d want 3", lat); end
    n_cmp++; if (re !== 1'b0 || rd !== 64'h1122334455667788) begin
      n_bad++; $display("FAIL rd10_data: got err=%b data=%h want 0 1122334455667788", re, rd);
    end
  endtask

  task automatic test_partial;
    int lat;
    logic [63:0] rd;
    logic re;
    xact(0, 64'h12, 3'd1, 8'h0C, 64'h00000000AABB0000, lat, rd, re);
    n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL wr12_err: got %b want 0", re); end
    xact(0, 64'h10, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (rd !== 64'h11223344AABB7788) begin n_bad++; $display("FAIL partial_data: got %h want 11223344aabb7788", rd); end
  endtask

  task automatic test_strobe_outside;
    int lat;
    logic [63:0] rd;
    logic re;
    xact(0, 64'h18, 3'd3, 8'hFF, 64'd0, lat, rd, re);
    xact(0, 64'h18, 3'd0, 8'h81, 64'hA1000000000000B2, lat, rd, re);
    n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL wr18_err: got %b want 0", re); end
    xact(0, 64'h18, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (rd !== 64'hA1000000000000B2) begin n_bad++; $display("FAIL nomask_data: got %h want a1000000000000b2", rd); end
  endtask

  task automatic test_errors;
    int lat;
    logic [63:0] rd;
    logic re;
    xact(0, 64'h13, 3'd2, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (lat !== 3 || re !== 1'b1 || rd !== 64'd0) begin
      n_bad++; $display("FAIL misalign_rd: got lat=%0d err=%b data=%h want 3 1 0", lat, re, rd);
    end
    xact(0, 64'h11, 3'd3, 8'hFF, 64'hFFFFFFFFFFFFFFFF, lat, rd, re);
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL misalign_wr: got err=%b data=%h want 1 0", re, rd); end
    xact(0, 64'h10, 3'd4, 8'hFF, 64'hFFFFFFFFFFFFFFFF, lat, rd, re);
    n_cmp++; if (re !== 1'b1) begin n_bad++; $display("FAIL illegal_size: got err=%b want 1", re); end
    xact(0, 64'h10, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (re !== 1'b0 || rd !== 64'h11223344AABB7788) begin
      n_bad++; $display("FAIL err_nowrite: got err=%b data=%h want 0 11223344aabb7788", re, rd);
    end
    xact(0, 64'h0, 3'd3, 8'hFF, 64'h0F0E0D0C0B0A0908, lat, rd, re);
    xact(0, 64'h80, 3'd3, 8'hFF, 64'hFFFFFFFFFFFFFFFF, lat, rd, re);
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL oob_wr: got err=%b data=%h want 1 0", re, rd); end
    xact(0, 64'h0, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (rd !== 64'h0F0E0D0C0B0A0908) begin n_bad++; $display("FAIL oob_nowrite: got %h want 0f0e0d0c0b0a0908", rd); end
    xact(0, 64'h8000000000000000, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL oob_high: got err=%b data=%h want 1 0", re, rd); end
  endtask

  task automatic test_back_to_back_lat0;
    int lat;
    logic [63:0] rd;
    logic re;
    logic exp_aok;
    logic exp_dok;
    @(posedge clk); #1;
    drive(1, 1'b1, 64'h8, 3'd3, 8'hFF, 64'hDEADBEEF00C0FFEE);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_aok = ((i % 2) == 0);
      exp_dok = ((i % 2) == 1);
      n_cmp++; if (aok0 !== exp_aok) begin n_bad++; $display("FAIL b2b_aok[%0d]: got %b want %b", i, aok0, exp_aok); end
      n_cmp++; if (dok0 !== exp_dok) begin n_bad++; $display("FAIL b2b_dok[%0d]: got %b want %b", i, dok0, exp_dok); end
      if (exp_dok) begin
        n_cmp++; if (rd0 !== 64'd0 || err0 !== 1'b0) begin n_bad++; $display("FAIL b2b_wresp[%0d]: got data=%h err=%b want 0 0", i, rd0, err0); end
      end
    end
    @(posedge clk); #1;
    drive(1, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
    @(negedge clk);
    xact(1, 64'h8, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (lat !== 1 || re !== 1'b0 || rd !== 64'hDEADBEEF00C0FFEE) begin
      n_bad++; $display("FAIL lat0_rd: got lat=%0d err=%b data=%h want 1 0 deadbeef00c0ffee", lat, re, rd);
    end
  endtask

  task automatic test_reset_in_wait;
    int lat;
    logic [63:0] rd;
    logic re;
    xact(0, 64'h20, 3'd3, 8'hFF, 64'h0123456789ABCDEF, lat, rd, re);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'h20, 3'd3, 8'hFF, 64'h5555AAAA5555AAAA);
    @(negedge clk);
    n_cmp++; if (aok2 !== 1'b1) begin n_bad++; $display("FAIL rw_aok: got %b want 1", aok2); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
    @(negedge clk);
    n_cmp++; if (dok2 !== 1'b0) begin n_bad++; $display("FAIL rw_dok_t1: got %b want 0", dok2); end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b1, 64'h20, 3'd3, 8'h00, 64'd0);
    @(negedge clk);
    n_cmp++; if (aok2 !== 1'b1) begin n_bad++; $display("FAIL rw_reaccept: got %b want 1", aok2); end
    @(negedge clk);
    n_cmp++; if (dok2 !== 1'b0) begin n_bad++; $display("FAIL rw_dok_t3: got %b want 0", dok2); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (dok2 !== 1'b1 || rd2 !== 64'h0123456789ABCDEF) begin
      n_bad++; $display("FAIL rw_old: got dok=%b data=%h want 1 0123456789abcdef", dok2, rd2);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
  endtask

  task automatic test_reset_in_resp;
    int lat;
    logic [63:0] rd;
    logic re;
    xact(0, 64'h28, 3'd3, 8'hFF, 64'h7766554433221100, lat, rd, re);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'h28, 3'd3, 8'hFF, 64'h99999999FFFFFFFF);
    @(negedge clk);
    n_cmp++; if (aok2 !== 1'b1) begin n_bad++; $display("FAIL rr_aok: got %b want 1", aok2); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (dok2 !== 1'b0) begin n_bad++; $display("FAIL rr_dok: got %b want 0", dok2); end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
    xact(0, 64'h28, 3'd3, 8'h00, 64'd0, lat, rd, re);
    n_cmp++; if (lat !== 3 || rd !== 64'h7766554433221100) begin
      n_bad++; $display("FAIL rr_old: got lat=%0d data=%h want 3 7766554433221100", lat, rd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_full();
    test_partial();
    test_strobe_outside();
    test_errors();
    test_back_to_back_lat0();
    test_reset_in_wait();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
